goofy_ram_arbiter: RTL

- Shares the single-port GoofyRam between three requesters: instruction fetch, microcode execution data accesses (RAM read/write bus A/B), and a DMA/IO port.
- Sits between the core and GoofyRam, and owns ram_save, ram_in and ram_addr.
- Each access is sequenced as grant, issue, then data return.
- Fixed priority with a starvation guard for DMA.

---
 rtl/goofy_ram_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/goofy_ram_arbiter.sv
// Arbiter sharing the single-port GoofyRam between instruction fetch, exec data and DMA.
// Define GOOFY_RAM_ARB_RR_EN for round-robin arbitration instead of fixed priority with DMA starvation guard.
module goofy_ram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              res,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    input  logic              exec_req,
    input  logic              exec_we,
    input  logic [ADDR_W-1:0] exec_addr,
    input  logic [DATA_W-1:0] exec_wdata,
    output logic              exec_gnt,
    output logic              exec_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_save,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_EXEC, OWN_FETCH, OWN_DMA} owner_t;

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    owner_t            winner;
    logic              arb_fire;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef GOOFY_RAM_ARB_RR_EN
    owner_t last_owner;

    // Search starts with the requester following the previous owner.
    always_comb begin
        winner = OWN_NONE;
        case (last_owner)
            OWN_EXEC: begin
                if (fetch_req)     winner = OWN_FETCH;
                else if (dma_req)  winner = OWN_DMA;
                else if (exec_req) winner = OWN_EXEC;
            end
            OWN_FETCH: begin
                if (dma_req)        winner = OWN_DMA;
                else if (exec_req)  winner = OWN_EXEC;
                else if (fetch_req) winner = OWN_FETCH;
            end
            default: begin
                if (exec_req)       winner = OWN_EXEC;
                else if (fetch_req) winner = OWN_FETCH;
                else if (dma_req)   winner = OWN_DMA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            last_owner <= OWN_DMA;
        end else if (arb_fire) begin
            last_owner <= winner;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    always_comb begin
        winner = OWN_NONE;
        if (dma_req && (starve_cnt >= STARVE_LIM)) winner = OWN_DMA;
        else if (exec_req)                          winner = OWN_EXEC;
        else if (fetch_req)                         winner = OWN_FETCH;
        else if (dma_req)                           winner = OWN_DMA;
    end

    // Counts consecutive lost arbitrations while DMA keeps asking; saturates at 15.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (!dma_req || (winner == OWN_DMA)) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`endif

    assign arb_fire = (state == IDLE) && (winner != OWN_NONE);
    assign busy     = (state != IDLE);

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = exec_addr;
        sel_wdata = exec_wdata;
        case (winner)
            OWN_EXEC: begin
                sel_we = exec_we;
            end
            OWN_FETCH: begin
                sel_addr  = fetch_addr;
                sel_wdata = '0;
            end
            OWN_DMA: begin
                sel_we    = dma_we;
                sel_addr  = dma_addr;
                sel_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    // ram_save is high only during ISSUE of a write, so it doubles as the latched write flag.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (winner != OWN_NONE) state_next = ISSUE;
            ISSUE:   state_next = ram_save ? IDLE : DATA;
            DATA:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state        <= IDLE;
            owner        <= OWN_NONE;
            ram_addr     <= '0;
            ram_in       <= '0;
            ram_save     <= 1'b0;
            rdata        <= '0;
            fetch_gnt    <= 1'b0;
            exec_gnt     <= 1'b0;
            dma_gnt      <= 1'b0;
            fetch_rvalid <= 1'b0;
            exec_rvalid  <= 1'b0;
            dma_rvalid   <= 1'b0;
        end else begin
            state        <= state_next;
            ram_save     <= 1'b0;
            fetch_gnt    <= 1'b0;
            exec_gnt     <= 1'b0;
            dma_gnt      <= 1'b0;
            fetch_rvalid <= 1'b0;
            exec_rvalid  <= 1'b0;
            dma_rvalid   <= 1'b0;
            if (arb_fire) begin
                owner     <= winner;
                ram_addr  <= sel_addr;
                ram_in    <= sel_wdata;
                ram_save  <= sel_we;
                fetch_gnt <= (winner == OWN_FETCH);
                exec_gnt  <= (winner == OWN_EXEC);
                dma_gnt   <= (winner == OWN_DMA);
            end
            if (state == DATA) begin
                rdata        <= ram_out;
                fetch_rvalid <= (owner == OWN_FETCH);
                exec_rvalid  <= (owner == OWN_EXEC);
                dma_rvalid   <= (owner == OWN_DMA);
            end
        end
    end

endmodule
